// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and widths for the cpu_ctrl fetch/decode/execute controller.
package cpu_pkg;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned REG_AW  = 4;
   localparam int unsigned OPC_W   = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_ADC  = 4'h4,
      OP_BZ   = 4'hD,
      OP_HALT = 4'hE,
      OP_B    = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // Decoded per-instruction controls, stable for as long as ir is held.
   typedef struct packed {
      logic    is_alu;
      logic    is_branch;
      logic    is_bz;
      logic    is_halt;
      logic    illegal;
      logic    imm_sel;
      alu_op_e alu_op;
   } dec_ctrl_t;

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(1);
   endfunction

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: combinational instruction decoder (ir -> controls, fields, illegal).
// Opcode 0xD decodes as BZ only when CPU_CTRL_BZ_EN is defined; otherwise it is illegal.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output dec_ctrl_t          ctrl,
   output logic [REG_AW-1:0]  rd,
   output logic [REG_AW-1:0]  rs,
   output logic [REG_AW-1:0]  rt,
   output logic [PC_W-1:0]    target,
   output logic [INSTR_W-1:0] imm
);

   assign rd     = ir[11:8];
   assign rs     = ir[7:4];
   assign rt     = ir[3:0];
   assign target = ir[7:0];
   assign imm    = INSTR_W'(ir[3:0]);

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (opcode_e'(ir[15:12]))
         OP_NOP: begin
            ctrl.is_alu = 1'b0;
         end
         OP_ADD: begin
            ctrl.is_alu = 1'b1;
         end
         OP_SUB: begin
            ctrl.is_alu = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_AND: begin
            ctrl.is_alu = 1'b1;
            ctrl.alu_op = ALU_AND;
         end
         OP_ADC: begin
            ctrl.is_alu  = 1'b1;
            ctrl.imm_sel = 1'b1;
         end
         OP_HALT: begin
            ctrl.is_halt = 1'b1;
         end
         OP_B: begin
            ctrl.is_branch = 1'b1;
         end
         OP_BZ: begin
`ifdef CPU_CTRL_BZ_EN
            ctrl.is_bz = 1'b1;
`else
            ctrl.illegal = 1'b1;
`endif
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/WB controller with an 8-bit wrapping pc.
// Build option CPU_CTRL_BZ_EN adds the BZ opcode (decoded in cpu_decode).
module cpu_ctrl
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [REG_AW-1:0]  rf_ra,
   output logic [REG_AW-1:0]  rf_rb,
   output logic               imm_sel,
   output logic [INSTR_W-1:0] imm,
   output logic [1:0]         alu_op,
   input  logic               alu_zero,
   output logic               rf_we,
   output logic [REG_AW-1:0]  rf_wa,
   output logic               halted,
   output logic               illegal
);

   state_e             state_q;
   state_e             state_d;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic               zflag_q;
   logic               fetch_done;

   dec_ctrl_t          ctrl;
   logic [REG_AW-1:0]  rd;
   logic [REG_AW-1:0]  rs;
   logic [REG_AW-1:0]  rt;
   logic [PC_W-1:0]    target;
   logic [INSTR_W-1:0] imm_ext;

   // Decode straight from ir: ir is held from DECODE through WB, so the controls are too.
   cpu_decode u_decode (
      .ir     (ir_q),
      .ctrl   (ctrl),
      .rd     (rd),
      .rs     (rs),
      .rt     (rt),
      .target (target),
      .imm    (imm_ext)
   );

   assign fetch_done = run && imem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (fetch_done) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (ctrl.is_alu) begin
               state_d = ST_WB;
            end else if (ctrl.is_halt) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // A request raised while rst is still high would be discarded by the edge, so mask it.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      rf_ra     = rs;
      rf_rb     = rt;
      imm       = imm_ext;
      imm_sel   = ctrl.imm_sel;
      alu_op    = ctrl.alu_op;
      rf_we     = 1'b0;
      rf_wa     = rd;
      halted    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = run && !rst;
         end
         ST_EXEC: begin
            illegal = ctrl.illegal;
         end
         ST_WB: begin
            rf_we = 1'b1;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         zflag_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (fetch_done) begin
                  ir_q <= imem_data;
               end
            end
            ST_EXEC: begin
               if (ctrl.is_branch) begin
                  pc_q <= target;
               end else if (ctrl.is_bz) begin
                  pc_q <= zflag_q ? target : pc_inc(pc_q);
               end else if (!ctrl.is_alu && !ctrl.is_halt) begin
                  pc_q <= pc_inc(pc_q);
               end
            end
            ST_WB: begin
               zflag_q <= alu_zero;
               pc_q    <= pc_inc(pc_q);
            end
            default: begin
               pc_q <= pc_q;
            end
         endcase
      end
   end

endmodule
